// File: rtl/prim_alert_pkg.sv
// Shared types and constants for the alert ping controller.
package prim_alert_pkg;

    // Ping scheduler states; Idle must stay at zero so a cleared register means Idle.
    typedef enum logic [1:0] {
        Idle = 2'b00,
        Wait = 2'b01,
        Ping = 2'b10
    } ping_ctrl_state_e;

    // Default width of the wait/timeout counters and their cycle-count inputs.
    localparam int unsigned PingCntDefault = 16;

endpackage

// File: rtl/prim_alert_ping_rr.sv
// Round-robin channel picker: finds the first enabled channel at or after
// the start pointer, wrapping modulo NumAlerts. Purely combinational.
module prim_alert_ping_rr #(
    parameter int unsigned NumAlerts = 4,
    localparam int unsigned IdxW = $clog2(NumAlerts)
) (
    input  logic [NumAlerts-1:0] en,
    input  logic [IdxW-1:0]      start,
    output logic                 found,
    output logic [IdxW-1:0]      idx
);

    localparam int unsigned DblW = $clog2(2 * NumAlerts);
    localparam logic [IdxW:0] NumW = (IdxW + 1)'(NumAlerts);

    logic [2*NumAlerts-1:0] dbl;
    logic [NumAlerts-1:0]   rot;
    logic [IdxW-1:0]        off;
    logic [IdxW:0]          sum;

    // Doubling the vector turns the rotate into a plain window select.
    assign dbl = {en, en};

    for (genvar gi = 0; gi < NumAlerts; gi++) begin : g_rot
        logic [DblW-1:0] pos;
        assign pos     = DblW'(gi) + DblW'(start);
        assign rot[gi] = dbl[pos];
    end

    // Priority-encode the rotated vector: lowest set bit is the nearest channel.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NumAlerts - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IdxW'(i);
            end
        end
    end

    // Un-rotate: offset back to an absolute channel index, modulo NumAlerts.
    assign sum = {1'b0, start} + {1'b0, off};
    assign idx = (sum >= NumW) ? IdxW'(sum - NumW) : sum[IdxW-1:0];

endmodule

// File: rtl/prim_alert_ping_ctrl.sv
// Multi-channel ping scheduler: pings enabled alert channels in round-robin
// order, waits for ping_ok and reports a timeout with the channel index.
module prim_alert_ping_ctrl
    import prim_alert_pkg::*;
#(
    parameter int unsigned NumAlerts = 4,
    parameter int unsigned CntW      = PingCntDefault,
    localparam int unsigned IdxW     = $clog2(NumAlerts)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [CntW-1:0]      wait_cyc_i,
    input  logic [CntW-1:0]      timeout_cyc_i,
    input  logic [NumAlerts-1:0] alert_en_i,
    input  logic [NumAlerts-1:0] ping_ok_i,
    output logic [NumAlerts-1:0] ping_en_o,
    output logic                 ping_fail_o,
    output logic [IdxW-1:0]      fail_idx_o
);

    ping_ctrl_state_e     state_reg;
    logic [CntW-1:0]      cnt_reg;
    logic [IdxW-1:0]      ptr_reg;
    logic [IdxW-1:0]      sel_reg;
    logic [NumAlerts-1:0] ping_en_reg;
    logic                 ping_fail_reg;
    logic [IdxW-1:0]      fail_idx_reg;

    logic                 rr_found;
    logic [IdxW-1:0]      rr_idx;
    logic [CntW-1:0]      wait_load;
    logic [CntW-1:0]      timeout_load;
    logic [IdxW-1:0]      sel_inc;

    prim_alert_ping_rr #(
        .NumAlerts(NumAlerts)
    ) u_rr (
        .en   (alert_en_i),
        .start(ptr_reg),
        .found(rr_found),
        .idx  (rr_idx)
    );

    // A zero cycle count is treated as one so the counters never start at zero.
    assign wait_load    = (wait_cyc_i == '0) ? CntW'(1) : wait_cyc_i;
    assign timeout_load = (timeout_cyc_i == '0) ? CntW'(1) : timeout_cyc_i;
    assign sel_inc      = (sel_reg == IdxW'(NumAlerts - 1)) ? '0 : sel_reg + IdxW'(1);

    // Scheduler FSM with counters, pointer and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= Idle;
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            sel_reg       <= '0;
            ping_en_reg   <= '0;
            ping_fail_reg <= 1'b0;
            fail_idx_reg  <= '0;
        end else begin
            ping_fail_reg <= 1'b0;
            if (!en_i) begin
                state_reg   <= Idle;
                cnt_reg     <= '0;
                ping_en_reg <= '0;
            end else begin
                case (state_reg)
                    Idle: begin
                        state_reg <= Wait;
                        cnt_reg   <= wait_load;
                    end
                    Wait: begin
                        if (cnt_reg > CntW'(1)) begin
                            cnt_reg <= cnt_reg - CntW'(1);
                        end else if (rr_found) begin
                            state_reg   <= Ping;
                            sel_reg     <= rr_idx;
                            ping_en_reg <= NumAlerts'(1) << rr_idx;
                            cnt_reg     <= timeout_load;
                        end else begin
                            cnt_reg <= wait_load;
                        end
                    end
                    Ping: begin
                        // ok beats an abort, which beats a timeout in the same cycle.
                        if (ping_ok_i[sel_reg] || !alert_en_i[sel_reg]) begin
                            state_reg   <= Wait;
                            ping_en_reg <= '0;
                            ptr_reg     <= sel_inc;
                            cnt_reg     <= wait_load;
                        end else if (cnt_reg > CntW'(1)) begin
                            cnt_reg <= cnt_reg - CntW'(1);
                        end else begin
                            state_reg     <= Wait;
                            ping_en_reg   <= '0;
                            ptr_reg       <= sel_inc;
                            cnt_reg       <= wait_load;
                            ping_fail_reg <= 1'b1;
                            fail_idx_reg  <= sel_reg;
                        end
                    end
                    default: begin
                        state_reg   <= Idle;
                        ping_en_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign ping_en_o   = ping_en_reg;
    assign ping_fail_o = ping_fail_reg;
    assign fail_idx_o  = fail_idx_reg;

endmodule

// File: tb/tb_prim_alert_ping_ctrl.sv
// Self-checking bench for prim_alert_ping_ctrl: directed scenarios plus a
// randomized run, compared each cycle against an event-time reference model.
`timescale 1ns/1ps
module tb_prim_alert_ping_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        en;
    logic [15:0] wait_cyc;
    logic [15:0] timeout_cyc;
    logic [3:0]  alert_en;
    logic [3:0]  ping_ok;
    logic [3:0]  ping_en;
    logic        ping_fail;
    logic [1:0]  fail_idx;

    prim_alert_ping_ctrl #(
        .NumAlerts(N),
        .CntW(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en),
        .wait_cyc_i   (wait_cyc),
        .timeout_cyc_i(timeout_cyc),
        .alert_en_i   (alert_en),
        .ping_ok_i    (ping_ok),
        .ping_en_o    (ping_en),
        .ping_fail_o  (ping_fail),
        .fail_idx_o   (fail_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model in absolute cycle numbers: when the next ping is due,
    // which channel is being pinged and at which cycle its timeout fires.
    int  cyc = 0;
    bit  m_run, m_ping, m_fail;
    int  m_ch, m_ptr, m_fail_idx, m_issue_at, m_expire_at;

    function automatic int ld(input logic [15:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    function automatic int find_ch(input int start);
        for (int i = 0; i < N; i++)
            if (alert_en[(start + i) % N]) return (start + i) % N;
        return -1;
    endfunction

    function automatic logic [3:0] model_pe();
        return m_ping ? 4'(1 << m_ch) : 4'b0;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int c = 0; c < N; c++) if (v[c]) return c;
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_ping = 0; m_fail = 0; m_ch = 0; m_ptr = 0; m_fail_idx = 0;
    endtask

    task automatic model_tick();
        m_fail = 0;
        if (!en) begin
            m_run = 0; m_ping = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_issue_at = cyc + ld(wait_cyc);
        end else if (!m_ping) begin
            if (cyc == m_issue_at) begin
                int c;
                c = find_ch(m_ptr);
                if (c >= 0) begin
                    m_ping = 1; m_ch = c;
                    m_expire_at = cyc + ld(timeout_cyc);
                end else begin
                    m_issue_at = cyc + ld(wait_cyc);
                end
            end
        end else if (ping_ok[m_ch] || !alert_en[m_ch] || cyc == m_expire_at) begin
            if (!ping_ok[m_ch] && alert_en[m_ch]) begin
                m_fail = 1; m_fail_idx = m_ch;
            end
            m_ping = 0;
            m_ptr = (m_ch + 1) % N;
            m_issue_at = cyc + ld(wait_cyc);
        end
    endtask

    // Receiver emulation and bookkeeping.
    int         delay[N];
    int         hi_cnt[N];
    int         last_len[N];
    bit         noise = 0;
    logic [3:0] force_ok = '0;
    int         plog[$];
    int         nfail = 0;
    int         last_fail_idx = -1;
    logic [3:0] prev_pe = '0;
    logic       prev_fail = 1'b0;

    task automatic compare();
        check("ping_en", ping_en, model_pe());
        check("ping_fail", ping_fail, m_fail);
        check("fail_idx", fail_idx, m_fail_idx);
        check("onehot0", $onehot0(ping_en), 1);
        check("idx_range", fail_idx < N, 1);
        check("fail_consec", ping_fail & prev_fail, 0);
        if (ping_en != 0 && prev_pe == 0) begin
            plog.push_back(onehot_idx(ping_en));
            $display("cyc %0d ping ch%0d", cyc, onehot_idx(ping_en));
        end
        if (ping_fail) begin
            nfail++;
            last_fail_idx = fail_idx;
            $display("cyc %0d ping_fail ch%0d", cyc, fail_idx);
        end
        prev_pe = ping_en;
        prev_fail = ping_fail;
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            if (ping_en[c]) hi_cnt[c]++;
            else begin
                if (hi_cnt[c] != 0) last_len[c] = hi_cnt[c];
                hi_cnt[c] = 0;
            end
            ping_ok[c] = (delay[c] != 0 && hi_cnt[c] == delay[c]);
        end
        ping_ok = ping_ok | force_ok;
        if (noise) ping_ok = ping_ok | (4'($urandom) & ~model_pe());
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_ni) model_reset(); else model_tick();
        @(negedge clk);
        compare();
        drive();
    endtask

    task automatic wait_ping(input int maxc);
        int n = 0;
        while (ping_en == 0 && n < maxc) begin
            step();
            n++;
        end
        check("wait_ping_bound", ping_en != 0, 1);
    endtask

    task automatic set_delays(input int d);
        for (int c = 0; c < N; c++) delay[c] = d;
    endtask

    initial begin
        rst_ni = 1'b0; en = 1'b0; wait_cyc = 16'd3; timeout_cyc = 16'd5;
        alert_en = 4'hf; ping_ok = '0;
        for (int c = 0; c < N; c++) begin hi_cnt[c] = 0; last_len[c] = 0; end
        set_delays(2);
        model_reset();
        repeat (3) step();
        check("reset_pe", ping_en, 0);
        check("reset_fail", ping_fail, 0);
        check("reset_idx", fail_idx, 0);
        rst_ni = 1'b1; en = 1'b1;

        // 1: all enabled, receivers answer after 2 cycles
        plog.delete(); nfail = 0;
        repeat (40) step();
        for (int i = 0; i < 5; i++)
            check("p1_order", (plog.size() > i) ? plog[i] : -1, i % N);
        check("p1_nofail", nfail, 0);

        // 2: ch2 never answers
        delay[2] = 0; plog.delete(); nfail = 0;
        repeat (60) step();
        check("p2_fail_seen", nfail > 0, 1);
        check("p2_fail_idx", last_fail_idx, 2);
        check("p2_len", last_len[2], 5);
        begin
            int nxt = -1;
            for (int i = 0; i + 1 < plog.size(); i++)
                if (plog[i] == 2 && nxt < 0) nxt = plog[i + 1];
            check("p2_next_after_2", nxt, 3);
        end

        // 3: only ch0 and ch2 enabled, then none
        delay[2] = 2; alert_en = 4'b0101; plog.delete();
        repeat (50) step();
        check("p3_count", plog.size() >= 4, 1);
        for (int i = 0; i + 1 < plog.size() && i < 6; i++) begin
            check("p3_set", (plog[i] == 0 || plog[i] == 2), 1);
            check("p3_alt", plog[i + 1], (plog[i] == 0) ? 2 : 0);
        end
        alert_en = 4'b0000;
        step();
        plog.delete();
        repeat (50) step();
        check("p3_none", plog.size(), 0);
        check("p3_none_pe", ping_en, 0);

        // 4: ok on the timeout cycle wins; ok on a non-selected channel is ignored
        alert_en = 4'hf; wait_cyc = 16'd2; timeout_cyc = 16'd3; set_delays(3);
        plog.delete(); nfail = 0;
        repeat (40) step();
        check("p4_pings", plog.size() >= 3, 1);
        check("p4_ok_wins", nfail, 0);
        alert_en = 4'b0001; delay[0] = 0; force_ok = 4'b0010; nfail = 0;
        repeat (30) step();
        check("p4_ign_fail", nfail > 0, 1);
        check("p4_ign_idx", last_fail_idx, 0);
        force_ok = '0;

        // 5: en_i dropped mid-ping, then reset mid-ping
        alert_en = 4'hf; set_delays(0); timeout_cyc = 16'd8; nfail = 0;
        wait_ping(40);
        en = 1'b0;
        step();
        check("p5_en_pe", ping_en, 0);
        check("p5_en_fail", ping_fail, 0);
        repeat (3) step();
        en = 1'b1;
        wait_ping(40);
        rst_ni = 1'b0;
        #1;
        check("p5_rst_pe", ping_en, 0);
        check("p5_rst_fail", ping_fail, 0);
        model_reset();
        repeat (2) step();
        rst_ni = 1'b1; set_delays(2);
        wait_ping(40);
        check("p5_restart_ch0", onehot_idx(ping_en), 0);
        check("p5_nofail", nfail, 0);

        // 6: zero wait/timeout behave as one
        wait_cyc = 16'd0; timeout_cyc = 16'd0; set_delays(0);
        plog.delete(); nfail = 0;
        repeat (30) step();
        check("p6_pings", plog.size() >= 3, 1);
        check("p6_fails", nfail >= 3, 1);
        check("p6_len", last_len[0], 1);

        // Randomized run against the model
        repeat (30) begin
            wait_cyc    = 16'($urandom_range(0, 4));
            timeout_cyc = 16'($urandom_range(0, 6));
            alert_en    = 4'($urandom);
            noise       = 1'($urandom_range(0, 1));
            for (int c = 0; c < N; c++) delay[c] = $urandom_range(0, 7);
            repeat (50) begin
                en = ($urandom_range(0, 99) != 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
